// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI bus bundle (AR/R/AW/W/B) between the
// interconnect and one SRAM-backed slave.
interface axi_sram_slave_if #(
  parameter int ID_W   = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic [ID_W-1:0]   ARID;
  logic [31:0]       ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;

  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  logic [ID_W-1:0]   AWID;
  logic [31:0]       AWADDR;
  logic [LEN_W-1:0]  AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;

  logic [DATA_W-1:0] WDATA;
  logic [3:0]        WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;

  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI INCR-burst slave driving a single-port SRAM macro.
// Define AXI_SRAM_SLV_RANGE_CHK_EN to answer out-of-range addresses with SLVERR.
module axi_sram_slave #(
  parameter int ID_W    = 8,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  axi_sram_slave_if.slave    bus,
  output logic               CEB,
  output logic               WEB,
  output logic [31:0]        BWEB,
  output logic [SRAM_AW-1:0] A,
  output logic [31:0]        DI,
  input  logic [31:0]        DO
);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_MEM,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                prio_q;
  logic [ID_W-1:0]     id_q;
  logic [SRAM_AW-1:0]  addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;
  logic                bad_q;
  logic                rd_first_q;
  logic [DATA_W-1:0]   rdata_q;

  logic grant_rd;
  logic grant_wr;
  logic ar_hs;
  logic aw_hs;
  logic r_hs;
  logic w_hs;
  logic rd_last;
  logic ar_bad;
  logic aw_bad;

  // prio_q low: reads win a tie
  assign grant_rd = bus.ARVALID && (!bus.AWVALID || !prio_q);
  assign grant_wr = bus.AWVALID && (!bus.ARVALID || prio_q);

  assign ar_hs   = rst && (state_q == IDLE) && grant_rd;
  assign aw_hs   = rst && (state_q == IDLE) && grant_wr;
  assign r_hs    = (state_q == RD_DATA) && bus.RREADY;
  assign w_hs    = (state_q == WR_DATA) && bus.WVALID;
  assign rd_last = (cnt_q == len_q);

`ifdef AXI_SRAM_SLV_RANGE_CHK_EN
  assign ar_bad = |bus.ARADDR[31:SRAM_AW+2];
  assign aw_bad = |bus.AWADDR[31:SRAM_AW+2];
`else
  assign ar_bad = 1'b0;
  assign aw_bad = 1'b0;

  logic unused_hi;
  assign unused_hi = ^{bus.ARADDR[31:SRAM_AW+2],
                       bus.AWADDR[31:SRAM_AW+2]};
`endif

  logic unused_attr;
  assign unused_attr = ^{bus.ARADDR[1:0], bus.AWADDR[1:0],
                         bus.ARSIZE, bus.ARBURST,
                         bus.AWSIZE, bus.AWBURST};

  always_comb begin
    state_d     = state_q;
    bus.ARREADY = 1'b0;
    bus.AWREADY = 1'b0;
    bus.RVALID  = 1'b0;
    bus.WREADY  = 1'b0;
    bus.BVALID  = 1'b0;
    bus.RID     = id_q;
    bus.RRESP   = OKAY;
    bus.RLAST   = 1'b0;
    bus.BID     = id_q;
    bus.BRESP   = OKAY;
    // DO is only valid in the first RD_DATA cycle; rdata_q holds it after
    bus.RDATA   = rdata_q;
    if (rd_first_q) begin
      bus.RDATA = bad_q ? '0 : DO;
    end
    CEB  = 1'b1;
    WEB  = 1'b1;
    BWEB = '1;
    A    = addr_q;
    DI   = '0;

    unique case (state_q)
      IDLE: begin
        bus.ARREADY = ar_hs;
        bus.AWREADY = aw_hs;
        if (ar_hs) begin
          state_d = RD_MEM;
        end else if (aw_hs) begin
          state_d = WR_DATA;
        end
      end
      RD_MEM: begin
        CEB     = bad_q;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        bus.RVALID = 1'b1;
        bus.RLAST  = rd_last;
        bus.RRESP  = bad_q ? SLVERR : OKAY;
        if (r_hs) begin
          state_d = rd_last ? IDLE : RD_MEM;
        end
      end
      WR_DATA: begin
        bus.WREADY = 1'b1;
        if (w_hs) begin
          CEB = bad_q;
          WEB = bad_q;
          if (!bad_q) begin
            DI = bus.WDATA;
            for (int k = 0; k < 4; k++) begin
              BWEB[8*k +: 8] = {8{~bus.WSTRB[k]}};
            end
          end
          if (bus.WLAST) begin
            state_d = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        bus.BVALID = 1'b1;
        bus.BRESP  = bad_q ? SLVERR : OKAY;
        if (bus.BREADY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      bad_q      <= 1'b0;
      rd_first_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_first_q <= (state_q == RD_MEM);
      if (rd_first_q) begin
        rdata_q <= bad_q ? '0 : DO;
      end
      if (ar_hs) begin
        id_q   <= bus.ARID;
        addr_q <= bus.ARADDR[SRAM_AW+1:2];
        len_q  <= bus.ARLEN;
        cnt_q  <= '0;
        bad_q  <= ar_bad;
        prio_q <= ~prio_q;
      end else if (aw_hs) begin
        id_q   <= bus.AWID;
        addr_q <= bus.AWADDR[SRAM_AW+1:2];
        len_q  <= bus.AWLEN;
        cnt_q  <= '0;
        bad_q  <= aw_bad;
        prio_q <= ~prio_q;
      end
      if ((r_hs && !rd_last) || w_hs) begin
        addr_q <= addr_q + SRAM_AW'(1);
        cnt_q  <= cnt_q + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: scoreboard bench for axi_sram_slave with a
// behavioural SRAM macro and a reference memory image.
module tb_axi_sram_slave;

  localparam int ID_W    = 8;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 4;
  localparam int SRAM_AW = 14;
  localparam int DEPTH   = 1 << SRAM_AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_sram_slave_if #(
    .ID_W(ID_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) bus ();

  logic               CEB;
  logic               WEB;
  logic [31:0]        BWEB;
  logic [SRAM_AW-1:0] A;
  logic [31:0]        DI;
  logic [31:0]        DO = '0;

  axi_sram_slave #(
    .ID_W(ID_W), .DATA_W(DATA_W),
    .LEN_W(LEN_W), .SRAM_AW(SRAM_AW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .CEB(CEB), .WEB(WEB), .BWEB(BWEB),
    .A(A), .DI(DI), .DO(DO)
  );

  logic [31:0] sram    [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (!CEB) begin
      if (!WEB) sram[A] <= (sram[A] & BWEB) | (DI & ~BWEB);
      else      DO <= sram[A];
    end
  end

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [7:0]  id;
  } rexp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [7:0] id;
  } bexp_t;

  rexp_t              rq[$];
  bexp_t              bq[$];
  logic [SRAM_AW-1:0] st_a[$];
  logic               st_we[$];
  logic [31:0]        st_bweb[$];
  int                 grant_q[$];
  int                 both_rdy = 0;
  int                 cyc = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst && !CEB) begin
      st_a.push_back(A);
      st_we.push_back(!WEB);
      st_bweb.push_back(BWEB);
    end
    if (bus.ARVALID && bus.ARREADY) grant_q.push_back(0);
    if (bus.AWVALID && bus.AWREADY) grant_q.push_back(1);
    if (bus.ARREADY && bus.AWREADY) both_rdy++;
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] addr);
`ifdef AXI_SRAM_SLV_RANGE_CHK_EN
    return |addr[31:SRAM_AW+2];
`else
    return 1'b0;
`endif
  endfunction

  task automatic clr_strobes();
    st_a.delete();
    st_we.delete();
    st_bweb.delete();
  endtask

  task automatic axi_write(input logic [7:0] id,
                           input logic [31:0] addr,
                           input int len);
    logic [SRAM_AW-1:0] w;
    logic               bad;
    bexp_t              e;
    int                 t;
    w   = addr[SRAM_AW+1:2];
    bad = is_bad(addr);
    e   = '{resp: bad ? 2'b10 : 2'b00, id: id};
    bq.push_back(e);
    for (int i = 0; i <= len; i++) begin
      for (int k = 0; k < 4; k++)
        if (!bad && ws[i][k]) ref_mem[w][8*k +: 8] = wd[i][8*k +: 8];
      w = w + SRAM_AW'(1);
    end
    @(posedge clk); #1;
    bus.AWID    = id;
    bus.AWADDR  = addr;
    bus.AWLEN   = len[LEN_W-1:0];
    bus.AWSIZE  = 3'd2;
    bus.AWBURST = 2'b01;
    bus.AWVALID = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!bus.AWREADY && t < 200);
    if (!bus.AWREADY) check("aw_timeout", 0, 1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.WDATA  = wd[i];
      bus.WSTRB  = ws[i];
      bus.WLAST  = (i == len);
      bus.WVALID = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end
      while (!bus.WREADY && t < 200);
      if (!bus.WREADY) check("w_timeout", 0, 1);
      @(posedge clk); #1;
    end
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!bus.BVALID && t < 200);
    if (!bus.BVALID) begin
      check("b_timeout", 0, 1);
    end else begin
      e = bq.pop_front();
      check("bresp", bus.BRESP, e.resp);
      check("bid", bus.BID, e.id);
      bus.BREADY = 1'b1;
      @(posedge clk); #1;
      bus.BREADY = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [7:0] id,
                          input logic [31:0] addr,
                          input int len,
                          input int stall_beat,
                          input int stall_cyc);
    logic [SRAM_AW-1:0] w;
    logic               bad;
    rexp_t              e;
    logic [31:0]        held;
    int                 t;
    int                 c0;
    int                 nchg;
    w   = addr[SRAM_AW+1:2];
    bad = is_bad(addr);
    for (int i = 0; i <= len; i++) begin
      e = '{data: bad ? 32'h0 : ref_mem[w],
            resp: bad ? 2'b10 : 2'b00,
            last: (i == len), id: id};
      rq.push_back(e);
      w = w + SRAM_AW'(1);
    end
    @(posedge clk); #1;
    bus.ARID    = id;
    bus.ARADDR  = addr;
    bus.ARLEN   = len[LEN_W-1:0];
    bus.ARSIZE  = 3'd2;
    bus.ARBURST = 2'b01;
    bus.ARVALID = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!bus.ARREADY && t < 200);
    if (!bus.ARREADY) check("ar_timeout", 0, 1);
    c0 = cyc;
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      t = 0;
      do begin @(negedge clk); t++; end
      while (!bus.RVALID && t < 200);
      if (!bus.RVALID) begin
        check("r_timeout", 0, 1);
      end else begin
        if (i == 0) check("r_latency", cyc - c0, 2);
        if (i == stall_beat) begin
          held = bus.RDATA;
          nchg = 0;
          repeat (stall_cyc) begin
            @(negedge clk);
            if (bus.RDATA !== held || !bus.RVALID) nchg++;
          end
          check("r_hold", nchg, 0);
        end
        e = rq.pop_front();
        check("rdata", bus.RDATA, e.data);
        check("rresp", bus.RRESP, e.resp);
        check("rlast", bus.RLAST, e.last);
        check("rid", bus.RID, e.id);
        bus.RREADY = 1'b1;
        @(posedge clk); #1;
        bus.RREADY = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0;
    bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0;
    bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
    bus.WVALID = 1'b0; bus.RREADY = 1'b0; bus.BREADY = 1'b0;

    // reset values, with requests pending
    #2 rst = 1'b0;
    bus.ARVALID = 1'b1;
    bus.AWVALID = 1'b1;
    #2;
    check("rst_arready", bus.ARREADY, 0);
    check("rst_awready", bus.AWREADY, 0);
    check("rst_rvalid", bus.RVALID, 0);
    check("rst_wready", bus.WREADY, 0);
    check("rst_bvalid", bus.BVALID, 0);
    check("rst_ceb", CEB, 1);
    check("rst_web", WEB, 1);
    check("rst_bweb", BWEB, 32'hFFFF_FFFF);
    check("rst_a", A, 0);
    check("rst_di", DI, 0);
    check("rst_rdata", bus.RDATA, 0);
    check("rst_rlast", bus.RLAST, 0);
    check("rst_resp", {bus.RRESP, bus.BRESP}, 0);
    check("rst_ids", {bus.RID, bus.BID}, 0);
    repeat (2) @(posedge clk);
    bus.ARVALID = 1'b0;
    bus.AWVALID = 1'b0;
    @(negedge clk) rst = 1'b1;

    // single write then read
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    axi_write(8'h01, 32'h0000_0010, 0);
    axi_read(8'h02, 32'h0000_0010, 0, -1, 0);

    // partial write
    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    axi_write(8'h03, 32'h0000_0020, 0);
    clr_strobes();
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    axi_write(8'h04, 32'h0000_0020, 0);
    check("pw_nstrobe", st_a.size(), 1);
    if (st_a.size() == 1) begin
      check("pw_bweb", st_bweb[0], 32'hFF00_FF00);
      check("pw_a", st_a[0], 14'h0008);
    end
    axi_read(8'h05, 32'h0000_0020, 0, -1, 0);

    // INCR burst of 4, read back plain then with a stalled beat
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(i + 1);
      ws[i] = 4'hF;
    end
    axi_write(8'h06, 32'h0000_0100, 3);
    for (int s = 0; s < 2; s++) begin
      clr_strobes();
      axi_read(8'h07, 32'h0000_0100, 3, s == 0 ? -1 : 1, 3);
      check("burst_nstrobe", st_a.size(), 4);
      if (st_a.size() == 4)
        for (int i = 0; i < 4; i++) begin
          check("burst_a", st_a[i], 14'h0040 + 14'(i));
          check("burst_rd", st_we[i], 0);
        end
    end

    // zero-strobe beat still pulses CEB but leaves memory alone
    clr_strobes();
    wd[0] = 32'h5555_5555; ws[0] = 4'h0;
    axi_write(8'h08, 32'h0000_0010, 0);
    check("zstrb_n", st_a.size(), 1);
    if (st_a.size() == 1) check("zstrb_bweb", st_bweb[0], 32'hFFFF_FFFF);
    axi_read(8'h09, 32'h0000_0010, 0, -1, 0);

    // address wrap at the top word
    clr_strobes();
    wd[0] = 32'hCAFE_0001; ws[0] = 4'hF;
    wd[1] = 32'hCAFE_0002; ws[1] = 4'hF;
    axi_write(8'h0A, 32'h0000_FFFC, 1);
    check("wrap_n", st_a.size(), 2);
    if (st_a.size() == 2) begin
      check("wrap_a0", st_a[0], 14'h3FFF);
      check("wrap_a1", st_a[1], 14'h0000);
    end
    axi_read(8'h0B, 32'h0000_FFFC, 1, -1, 0);

    // address above the SRAM range
    clr_strobes();
    axi_read(8'h0C, 32'h0001_0000, 0, -1, 0);
`ifdef AXI_SRAM_SLV_RANGE_CHK_EN
    check("oor_rd_strobes", st_a.size(), 0);
`else
    check("oor_rd_strobes", st_a.size(), 1);
`endif
    wd[0] = 32'h0BAD_0BAD; ws[0] = 4'hF;
    axi_write(8'h0D, 32'h0001_0004, 0);
    axi_read(8'h0E, 32'h0000_0004, 0, -1, 0);

    // data for the arbitration reads
    wd[0] = 32'h0000_0200; ws[0] = 4'hF;
    axi_write(8'h0F, 32'h0000_0200, 0);

    // reset in the middle of a read burst
    @(posedge clk); #1;
    bus.ARID = 8'h10; bus.ARADDR = 32'h0000_0100;
    bus.ARLEN = 4'd3; bus.ARVALID = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!bus.ARREADY && t < 200);
    if (!bus.ARREADY) check("mid_ar_timeout", 0, 1);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end
    while (!bus.RVALID && t < 200);
    if (!bus.RVALID) check("mid_r_timeout", 0, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_rvalid", bus.RVALID, 0);
    check("mid_rst_ceb", CEB, 1);
    @(negedge clk) rst = 1'b1;
    grant_q.delete();

    // both channels request together, twice
    for (int r = 0; r < 2; r++) begin
      wd[0] = 32'h7000_0000 + 32'(r); ws[0] = 4'hF;
      fork
        axi_read(8'h21, 32'h0000_0200, 0, -1, 0);
        axi_write(8'h22, 32'h0000_0204, 0);
      join
    end
    check("grant_n", grant_q.size(), 4);
    if (grant_q.size() == 4)
      for (int i = 0; i < 4; i++) check("grant_order", grant_q[i], i % 2);
    axi_read(8'h23, 32'h0000_0204, 0, -1, 0);

    check("ar_aw_excl", both_rdy, 0);
    check("rq_empty", rq.size(), 0);
    check("bq_empty", bq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI slave that turns one bridge-side slave port (AR/R/AW/W/B) into single-port SRAM macro controls (CEB/WEB/BWEB/A/DI/DO).
- Sits directly downstream of the interconnect that the CPU-side IM/DM AXI masters drive; one instance per memory (IM, DM).
- Handles INCR bursts, one transaction at a time, with fair read/write arbitration.

Parameters:
- ID_W, 8, slave-side ID width (master ID plus bridge-added master index).
- DATA_W, 32, data width; fixed 4-byte beats.
- LEN_W, 4, burst length field width (1..16 beats).
- SRAM_AW, 14, SRAM word-address width (16384 words, 64 KiB).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/32/LEN_W/3/2  read address
- ARVALID in 1 / ARREADY out 1  read address handshake
- RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  read data
- RVALID out 1 / RREADY in 1  read data handshake
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/32/LEN_W/3/2  write address
- AWVALID in 1 / AWREADY out 1  write address handshake
- WDATA/WSTRB/WLAST  in  DATA_W/4/1  write data
- WVALID in 1 / WREADY out 1  write data handshake
- BID/BRESP  out  ID_W/2  write response
- BVALID out 1 / BREADY in 1  write response handshake
- CEB  out  1  SRAM chip enable, active low
- WEB  out  1  SRAM write enable, active low
- BWEB  out  32  SRAM bit write enable, active low
- A  out  SRAM_AW  SRAM word address
- DI  out  32  SRAM write data
- DO  in  32  SRAM read data, valid one cycle after a read strobe

Behaviour:
- FSM states: IDLE, RD_MEM, RD_DATA, WR_DATA, WR_RESP.
- Reset: state IDLE; prio=read; all VALID/READY low; CEB=1; WEB=1; BWEB=all 1s; A=0; DI=0; RDATA=0; RRESP=BRESP=2'b00; RID=BID=0; RLAST=0.
- Reset asserted mid-burst: return to IDLE immediately and drop the burst. No response is issued.
- IDLE:
  - ARREADY = (IDLE && grant_rd); AWREADY = (IDLE && grant_wr). Both are combinational from the registered state and forced 0 while rst=0.
  - Only one valid: grant that channel.
  - Both valid: grant per prio. prio toggles after every granted transaction (read granted first after reset).
  - On handshake: latch ID, addr word index = ADDR[SRAM_AW+1:2], LEN, beat cnt=0.
- Read path:
  - IDLE -> RD_MEM on AR handshake.
  - RD_MEM (1 cycle): CEB=0, WEB=1, A=addr. Next state RD_DATA.
  - RD_DATA: RDATA registered from DO on entry and held stable while RVALID=1; RVALID=1; RID=latched ID; RRESP=OKAY; RLAST=(cnt==len).
  - On RVALID&&RREADY: last beat -> IDLE; otherwise addr+1, cnt+1, -> RD_MEM.
  - Latency: AR handshake at cycle T -> first RVALID at T+2. One beat every 2 cycles.
- Write path:
  - IDLE -> WR_DATA on AW handshake.
  - WR_DATA: WREADY=1. On WVALID&&WREADY (same cycle, combinational): CEB=0, WEB=0, A=addr, DI=WDATA, BWEB byte k = {8{~WSTRB[k]}}. Then addr+1, cnt+1.
  - WSTRB=0 beat: strobe still issued with BWEB all 1s (no bytes change).
  - WLAST accepted -> WR_RESP. The burst ends on WLAST only, regardless of cnt vs len.
  - WR_RESP: BVALID=1, BID=latched ID, BRESP=OKAY. On BREADY -> IDLE.
- Outside RD_MEM and write beats: CEB=1, WEB=1, BWEB=all 1s.
- Address increment wraps modulo 2^SRAM_AW.
- ARSIZE/AWSIZE ignored (4-byte beats). Any BURST encoding is treated as INCR.
- New AR/AW are never accepted outside IDLE.

Optional Feature:
- Macro AXI_SRAM_SLV_RANGE_CHK_EN.
- Defined:
  - An address with ADDR[31:SRAM_AW+2] != 0 at handshake marks the transaction bad.
  - Bad read: no SRAM strobe. Beats still stepped through RD_MEM/RD_DATA with RDATA=0 and RRESP=2'b10 (SLVERR).
  - Bad write: W beats are accepted, CEB stays 1, BRESP=2'b10.
- Undefined: upper address bits ignored (aliasing); RESP always OKAY.

Test Plan:
- Single write then read: AW addr=0x0000_0010, len=0, WDATA=0xDEADBEEF, WSTRB=4'hF -> BVALID with BRESP=0; then AR same addr -> RDATA=0xDEADBEEF, RLAST=1, RVALID exactly 2 cycles after AR handshake.
- Partial write: pre-write 0x11223344, then write WSTRB=4'b0101 with data 0xAABBCCDD -> BWEB=0xFF00FF00 at strobe; readback 0x11BB33DD.
- INCR burst len=3 from addr 0x100: write 1,2,3,4, then read the same -> RDATA 1,2,3,4; SRAM A=0x40..0x43; RLAST only on beat 4. Repeat with RREADY low for 3 cycles on beat 2 -> RDATA held, no extra SRAM strobe.
- Simultaneous ARVALID and AWVALID twice in a row after reset -> read granted first, write second; ARREADY and AWREADY never high in the same cycle.
- Wrap: write burst len=1 starting at word 0x3FFF -> second beat lands at A=0; rst pulled low during RD_DATA -> RVALID=0, CEB=1 next edge, and a new AR is accepted after release.
- AXI_SRAM_SLV_RANGE_CHK_EN defined: read of 0x0001_0000 (SRAM_AW=14) -> RRESP=2'b10, RDATA=0, CEB never low; write -> BRESP=2'b10.
